pipe_stage_reg: RTL

//  Parametrised pipeline stage register for the MIPS pipeline; successor to the fixed EX/MEM register.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
//   - Control-field bit offsets in the EX/MEM control vector.
//   - The NOP control encoding that is driven whenever a stage holds no valid entry.
//   - Per-stage control widths and data word counts for ID/EX, EX/MEM and MEM/WB.
// No ports. The top-level register is pipe_stage_reg.
package pipe_pkg;

    // EX/MEM control layout: PCSrc[7:5] RegWr[4] MemWr[3] MemRd[2] MemToReg[1:0]
    localparam int unsigned CTRL_PCSRC_LSB    = 5;
    localparam int unsigned CTRL_PCSRC_W      = 3;
    localparam int unsigned CTRL_REGWR_BIT    = 4;
    localparam int unsigned CTRL_MEMWR_BIT    = 3;
    localparam int unsigned CTRL_MEMRD_BIT    = 2;
    localparam int unsigned CTRL_MEMTOREG_LSB = 0;
    localparam int unsigned CTRL_MEMTOREG_W   = 2;

    // All-zero control is a bubble: no register write and no memory access.
    localparam logic [7:0] CTRL_NOP = 8'h00;

    // Per-stage instantiation constants.
    localparam int unsigned IDEX_CTRL_W   = 12;
    localparam int unsigned IDEX_N_WORDS  = 4;
    localparam int unsigned EXMEM_CTRL_W  = 8;
    localparam int unsigned EXMEM_N_WORDS = 4;
    localparam int unsigned MEMWB_CTRL_W  = 3;
    localparam int unsigned MEMWB_N_WORDS = 3;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage register: a valid bit plus a payload flop.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears valid and payload)
//   load   in   capture d into the payload and set valid
//   clr    in   clear valid (has priority over load); payload keeps its value
//   d      in   W   payload to capture
//   valid  out  slot holds an entry
//   q      out  W   stored payload
module pipe_slot #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                q     <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS pipeline stage register (ID/EX, EX/MEM, MEM/WB) with a valid/ready
// handshake, a main + skid slot pair for stalls, and a synchronous flush that inserts a bubble.
// Optional feature macro: PSR_PERF_CNT_EN enables saturating stall/flush counters; when it is
// undefined the counter outputs are constant zero and no counter flops exist.
// Ports:
//   clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset
//   flush      in   drop all held and incoming entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept (registered: !skid_valid)
//   ctrl_in    in   CTRL_W control fields
//   data_in    in   N_WORDS*DATA_W packed data words, word 0 at LSB
//   rd_in      in   ADDR_W destination register address
//   out_valid  out  downstream entry valid
//   out_ready  in   downstream accepts
//   ctrl_out   out  control, forced to NOP when out_valid=0
//   data_out   out  data words of the main slot
//   rd_out     out  destination address of the main slot
//   stall_cnt  out  CNT_W cycles with out_valid & !out_ready
//   flush_cnt  out  CNT_W flushes that discarded at least one valid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W  = EXMEM_CTRL_W,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_WORDS = EXMEM_N_WORDS,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         ctrl_in,
    input  logic [N_WORDS*DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0]         rd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         ctrl_out,
    output logic [N_WORDS*DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0]         rd_out,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int unsigned PAY_W = CTRL_W + N_WORDS * DATA_W + ADDR_W;

    logic             main_valid, skid_valid;
    logic [PAY_W-1:0] main_q, skid_q, main_d, in_payload;
    logic             main_load, main_clr, skid_load, skid_clr;
    logic             accept, pop;

    assign in_payload = {ctrl_in, data_in, rd_in};

    // Ready depends only on a flop so no combinational ready chain forms across stages.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_valid & out_ready;

    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = in_payload;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (pop) begin
            if (skid_valid) begin
                // Skid is older than anything upstream; in_ready was low so nothing is accepted.
                main_load = 1'b1;
                main_d    = skid_q;
                skid_clr  = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(
        .W (PAY_W)
    ) u_main (
        .clk   (clk),
        .rst_n (Reset),
        .load  (main_load),
        .clr   (main_clr),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(
        .W (PAY_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (Reset),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign out_valid = main_valid;
    assign ctrl_out  = main_valid ? main_q[PAY_W-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
    assign data_out  = main_q[ADDR_W +: N_WORDS*DATA_W];
    assign rd_out    = main_q[ADDR_W-1:0];

`ifdef PSR_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (main_valid && !out_ready && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush && (main_valid || skid_valid) && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
